// File: rtl/data_mem_bridge.sv
// data_mem_bridge: turns the core's level-style load/store request into a
// valid/ready bus transaction. It also handles RV32 byte lanes, load
// extension, misalignment checks and a bus timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a request from the core; busy low
// S_REQ    | bus_valid high, holding address/strobes until bus_ready
// S_WAIT_R | read accepted, waiting for bus_rvalid
// S_DONE   | one-cycle done pulse, err low
// S_ERR    | one-cycle done pulse with err high (illegal request or timeout)
module data_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT_R = 3'd2,
      S_DONE   = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic                r_bus_we;
   logic [3:0]          r_bus_wstrb;
   logic [31:0]         r_bus_wdata;
   logic [2:0]          r_funct3;
   logic [1:0]          r_addr_lo;
   logic [CNT_W-1:0]    r_cnt;
   logic [31:0]         r_rdata;

   logic                w_one_req;
   logic                w_legal;
   logic                w_accept;
   logic [3:0]          w_wstrb;
   logic [31:0]         w_wdata;
   logic [31:0]         w_load;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_timeout;

   assign w_one_req = req_read ^ req_write;
   assign w_accept  = (r_state == S_IDLE) && w_one_req && w_legal;
   assign w_cnt_nxt = r_cnt + CNT_W'(1);
   // A zero parameter turns the timeout off entirely.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == TO_VAL);

   // Legality of the request presented in IDLE.
   always_comb begin
      w_legal = 1'b1;
      case (req_funct3)
         3'd0, 3'd4: w_legal = 1'b1;
         3'd1, 3'd5: w_legal = ~req_addr[0];
         3'd2:       w_legal = (req_addr[1:0] == 2'b00);
         default:    w_legal = 1'b0;
      endcase
      // Sub-word unsigned forms only make sense for loads.
      if (req_write && req_funct3[2]) begin
         w_legal = 1'b0;
      end
   end

   // Store lane steering; loads put no strobes on the bus.
   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = 32'h0;
      if (req_write) begin
         case (req_funct3[1:0])
            2'd0: begin
               w_wstrb = 4'b0001 << req_addr[1:0];
               w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
               w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               w_wstrb = 4'b1111;
               w_wdata = req_wdata;
            end
         endcase
      end
   end

   // Load lane extraction and sign/zero extension.
   always_comb begin
      w_byte = bus_rdata[8*r_addr_lo +: 8];
      w_half = bus_rdata[16*r_addr_lo[1] +: 16];
      case (r_funct3)
         3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load = {{16{w_half[15]}}, w_half};
         3'd4:    w_load = {24'h0, w_byte};
         3'd5:    w_load = {16'h0, w_half};
         default: w_load = bus_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. Bus handshakes win over a timeout landing in the same
   // cycle, since the memory has then already taken the request.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_read && req_write) begin
               w_state_nxt = S_ERR;
            end else if (w_one_req) begin
               w_state_nxt = w_legal ? S_REQ : S_ERR;
            end
         end
         S_REQ: begin
            if (bus_ready) begin
               w_state_nxt = r_bus_we ? S_DONE : S_WAIT_R;
            end else if (w_timeout) begin
               w_state_nxt = S_ERR;
            end
         end
         S_WAIT_R: begin
            if (bus_rvalid) begin
               w_state_nxt = S_DONE;
            end else if (w_timeout) begin
               w_state_nxt = S_ERR;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Latch the bus-side request fields when a legal request is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bus_addr  <= '0;
         r_bus_we    <= 1'b0;
         r_bus_wstrb <= 4'b0000;
         r_bus_wdata <= 32'h0;
         r_funct3    <= 3'd0;
         r_addr_lo   <= 2'd0;
      end else if (w_accept) begin
         r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
         r_bus_we    <= req_write;
         r_bus_wstrb <= w_wstrb;
         r_bus_wdata <= w_wdata;
         r_funct3    <= req_funct3;
         r_addr_lo   <= req_addr[1:0];
      end
   end

   // Timeout counter: held at zero in IDLE so it starts clean on entering REQ.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT_R)) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // Load result register, updated only by a completed read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rdata <= 32'h0;
      end else if ((r_state == S_WAIT_R) && bus_rvalid) begin
         r_rdata <= w_load;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE) || (r_state == S_ERR);
   assign err       = (r_state == S_ERR);
   assign rdata     = r_rdata;
   assign bus_valid = (r_state == S_REQ);
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wstrb = r_bus_wstrb;
   assign bus_wdata = r_bus_wdata;

endmodule
